// File: rtl/e_mem_banked_clr.sv
// ---------------------------------------------------------------------------
// e_mem_banked_clr
// Multi-bank store for compressed check-node messages {min1,min2,idx,signs}
// of the layered LDPC decoder. One bank per parallel row group; all banks
// share the read address and the write address. Contents cannot be reset, so
// a clear sequencer walks every address writing zero after reset and on
// clr_start.
//
// Ports
//   clk        clock
//   rst        synchronous active-low reset
//   clr_start  pulse: start clearing all banks (ignored while clearing)
//   clr_busy   high while the clear sequencer runs
//   wr_en      per-bank write enable
//   wr_addr    write address, shared by all banks
//   din        write data, bank b at [b*ECOMPSIZE +: ECOMPSIZE]
//   rd_en      read enable, all banks
//   rd_addr    read address
//   dout       read data, same packing as din
//   dout_vld   dout holds valid read data
// ---------------------------------------------------------------------------
module e_mem_banked_clr #(
  parameter int unsigned NBANK     = 4,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned ADDRWIDTH = 9,
  parameter int unsigned W         = 6,
  parameter int unsigned WC        = 32,
  parameter int unsigned WCBITS    = 5,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BYPASS    = 1,
  localparam int unsigned ECOMPSIZE = 2 * (W - 1) + WCBITS + WC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_start,
  output logic                         clr_busy,
  input  logic [NBANK-1:0]             wr_en,
  input  logic [ADDRWIDTH-1:0]         wr_addr,
  input  logic [NBANK*ECOMPSIZE-1:0]   din,
  input  logic                         rd_en,
  input  logic [ADDRWIDTH-1:0]         rd_addr,
  output logic [NBANK*ECOMPSIZE-1:0]   dout,
  output logic                         dout_vld
);

  localparam int unsigned DW = NBANK * ECOMPSIZE;
  localparam logic [ADDRWIDTH:0]   DEPTH_W   = (ADDRWIDTH + 1)'(DEPTH);
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   cnt_q, cnt_d;
  logic                   clr_busy_q, clr_busy_d;

  logic                   clr_we_c;
  logic                   idle_c;
  logic                   wr_ok_c;
  logic                   rd_ok_c;
  logic                   addr_hit_c;
  logic                   vld1_q;
  logic [DW-1:0]          dout1_c;

  // Clear sequencer state register; reset lands in CLEAR so stale BRAM data is flushed
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      clr_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  // Clear sequencer next state: one address per cycle, DEPTH cycles total
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_busy_d = clr_busy_q;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDRWIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    clr_busy_d = (state_d == S_CLEAR);
  end

  assign clr_busy = clr_busy_q;

  // Gating shared by all banks; nothing is written while rst is asserted
  assign clr_we_c   = rst && (state_q == S_CLEAR);
  assign idle_c     = rst && (state_q == S_IDLE);
  assign wr_ok_c    = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok_c    = idle_c && rd_en && ({1'b0, rd_addr} < DEPTH_W);
  assign addr_hit_c = (wr_addr == rd_addr);

  // First read stage valid flag, aligned with the bank read registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= rd_ok_c;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [ECOMPSIZE-1:0] mem_q [DEPTH];
    logic [ECOMPSIZE-1:0] rdata_q;
    logic                 we_c;
    logic [ADDRWIDTH-1:0] waddr_c;
    logic [ECOMPSIZE-1:0] wdata_c;
    logic                 byp_c;

    // Write port mux: the clear sequencer owns the port while running
    always_comb begin
      we_c    = 1'b0;
      waddr_c = wr_addr;
      wdata_c = din[b*ECOMPSIZE +: ECOMPSIZE];
      if (clr_we_c) begin
        we_c    = 1'b1;
        waddr_c = cnt_q;
        wdata_c = '0;
      end else if (idle_c && wr_en[b] && wr_ok_c) begin
        we_c = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (we_c) begin
        mem_q[waddr_c] <= wdata_c;
      end
    end

    // Write-first forwarding only for the bank being written at the read address
    assign byp_c = (BYPASS != 0) && wr_en[b] && addr_hit_c;

    always_ff @(posedge clk) begin
      if (!rst) begin
        rdata_q <= '0;
      end else if (rd_ok_c) begin
        rdata_q <= byp_c ? din[b*ECOMPSIZE +: ECOMPSIZE] : mem_q[rd_addr];
      end else begin
        rdata_q <= '0;
      end
    end

    assign dout1_c[b*ECOMPSIZE +: ECOMPSIZE] = rdata_q;
  end

  // Optional output register stage
  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] dout2_q;
    logic          vld2_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        dout2_q <= '0;
        vld2_q  <= 1'b0;
      end else begin
        dout2_q <= dout1_c;
        vld2_q  <= vld1_q;
      end
    end

    assign dout     = dout2_q;
    assign dout_vld = vld2_q;
  end else begin : g_lat1
    assign dout     = dout1_c;
    assign dout_vld = vld1_q;
  end

endmodule

// File: tb/tb_e_mem_banked_clr.sv
module tb_e_mem_banked_clr;

  localparam int unsigned NBANK  = 4;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned AW     = 9;
  localparam int unsigned EW     = 47;
  localparam int unsigned DW     = NBANK * EW;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned BYPASS = 1;

  logic              clk;
  logic              rst;
  logic              clr_start;
  logic              clr_busy;
  logic [NBANK-1:0]  wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     din;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     dout;
  logic              dout_vld;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays plus a count of outstanding clear cycles
  logic [EW-1:0] mmem [NBANK][DEPTH];
  logic [DW-1:0] pd [RD_LAT];
  logic          pv [RD_LAT];
  logic          m_busy;
  int unsigned   m_ccnt;
  logic [DW-1:0] exp_dout;
  logic          exp_vld;

  e_mem_banked_clr #(
    .NBANK(NBANK), .DEPTH(DEPTH), .ADDRWIDTH(AW), .W(6), .WC(32), .WCBITS(5),
    .RD_LAT(RD_LAT), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout), .dout_vld(dout_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] place(input int b, input logic [EW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[b*EW +: EW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_d();
    logic [DW-1:0] r;
    for (int b = 0; b < int'(NBANK); b++) r[b*EW +: EW] = EW'({$urandom(), $urandom()});
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply the memory rules for one clock edge with the given inputs
  task automatic model_edge(input logic r, input logic c, input logic [NBANK-1:0] we,
                            input logic [AW-1:0] wa, input logic [DW-1:0] d,
                            input logic re, input logic [AW-1:0] ra);
    logic [DW-1:0] rd;
    logic          rv;
    if (!r) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin pd[i] = '0; pv[i] = 1'b0; end
      m_busy = 1'b1;
      m_ccnt = 0;
    end else begin
      rv = 1'b0;
      rd = '0;
      if (re && !m_busy && int'(ra) < int'(DEPTH)) begin
        rv = 1'b1;
        for (int b = 0; b < int'(NBANK); b++)
          rd[b*EW +: EW] = (BYPASS != 0 && we[b] && wa == ra) ? d[b*EW +: EW] : mmem[b][ra];
      end
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin pd[i] = pd[i-1]; pv[i] = pv[i-1]; end
      pd[0] = rd;
      pv[0] = rv;
      if (m_busy) begin
        for (int b = 0; b < int'(NBANK); b++) mmem[b][m_ccnt[AW-1:0]] = '0;
        m_ccnt++;
        if (m_ccnt == DEPTH) m_busy = 1'b0;
      end else begin
        for (int b = 0; b < int'(NBANK); b++)
          if (we[b] && int'(wa) < int'(DEPTH)) mmem[b][wa] = d[b*EW +: EW];
        if (c) begin m_busy = 1'b1; m_ccnt = 0; end
      end
    end
    exp_dout = pd[RD_LAT-1];
    exp_vld  = pv[RD_LAT-1];
  endtask

  // Drive one cycle (called at a falling edge), update model, check at next falling edge
  task automatic step(input logic r, input logic c, input logic [NBANK-1:0] we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] d,
                      input logic re, input logic [AW-1:0] ra);
    rst = r; clr_start = c; wr_en = we; wr_addr = wa; din = d; rd_en = re; rd_addr = ra;
    @(posedge clk);
    model_edge(r, c, we, wa, d, re, ra);
    @(negedge clk);
    chk("model_dout", dout, exp_dout);
    chk("model_vld", {{(DW-1){1'b0}}, dout_vld}, {{(DW-1){1'b0}}, exp_vld});
    chk("model_busy", {{(DW-1){1'b0}}, clr_busy}, {{(DW-1){1'b0}}, m_busy});
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Count cycles with clr_busy high; random writes/reads and a stray clr_start meanwhile
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (clr_busy === 1'b1 && n < int'(DEPTH) + 20) begin
      step(1'b1, (n == 37), NBANK'($urandom()), AW'($urandom_range(0, 31)), rand_d(),
           1'b1, AW'($urandom_range(0, 31)));
      n++;
    end
    chk(name, DW'(n), DW'(DEPTH));
  endtask

  task automatic check_zero_range(input string name, input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      step(1'b1, 1'b0, '0, '0, '0, 1'b1, AW'(a));
      chk(name, dout, '0);
    end
  endtask

  typedef struct {
    int            wbank;
    logic [AW-1:0] wa;
    logic [EW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          exp_vld;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [EW-1:0] va, vb, vc, vd, ve;
    logic [DW-1:0] d;
    logic [NBANK-1:0] we;

    for (int b = 0; b < int'(NBANK); b++)
      for (int a = 0; a < int'(DEPTH); a++) mmem[b][a] = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin pd[i] = '0; pv[i] = 1'b0; end
    m_busy = 1'b1; m_ccnt = 0;

    va = 47'h1234_5678_9AB;
    vb = 47'h0BBB_CCCC_DDD;
    vc = 47'h5555_AAAA_555;
    vd = 47'h7FFF_0000_FFF;
    ve = 47'h0AAA_0000_111;

    vt.push_back('{2,  AW'(5), va, 1'b0, AW'(0), 1'b0, '0});
    vt.push_back('{-1, AW'(0), '0, 1'b1, AW'(5), 1'b1, place(2, va)});
    vt.push_back('{0,  AW'(7), ve, 1'b0, AW'(0), 1'b0, '0});
    vt.push_back('{0,  AW'(7), vb, 1'b1, AW'(7), 1'b1, place(0, (BYPASS != 0) ? vb : ve)});
    vt.push_back('{-1, AW'(0), '0, 1'b1, AW'(7), 1'b1, place(0, vb)});
    vt.push_back('{-1, AW'(0), '0, 1'b0, AW'(7), 1'b0, '0});
    vt.push_back('{1,  AW'(9), vc, 1'b1, AW'(9), 1'b1, place(1, (BYPASS != 0) ? vc : '0)});
    vt.push_back('{3,  AW'(5), vd, 1'b1, AW'(5), 1'b1,
                   place(2, va) | place(3, (BYPASS != 0) ? vd : '0)});
    vt.push_back('{-1, AW'(0), '0, 1'b1, AW'(5), 1'b1, place(2, va) | place(3, vd)});
    vt.push_back('{-1, AW'(0), '0, 1'b1, AW'(6), 1'b1, '0});

    // Reset held: outputs cleared, sequencer already reported busy
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    chk("reset_dout", dout, '0);
    chk("reset_vld", {{(DW-1){1'b0}}, dout_vld}, '0);

    // Power-on clear lasts DEPTH cycles, then whole memory reads zero
    count_busy("poweron_clear_len");
    check_zero_range("poweron_zero", 0, int'(DEPTH) - 1);

    // Directed vectors: single-bank write, collisions, read gaps
    foreach (vt[i]) begin
      d  = {DW{1'b1}};
      we = '0;
      if (vt[i].wbank >= 0) begin
        d[vt[i].wbank*EW +: EW] = vt[i].wd;
        we[vt[i].wbank] = 1'b1;
      end
      step(1'b1, 1'b0, we, vt[i].wa, d, vt[i].re, vt[i].ra);
      chk($sformatf("vec%0d_dout", i), dout, vt[i].exp_dout);
      chk($sformatf("vec%0d_vld", i), {{(DW-1){1'b0}}, dout_vld}, {{(DW-1){1'b0}}, vt[i].exp_vld});
    end

    // Streaming reads of addr*3 then an idle slot
    for (int a = 0; a < 16; a++) step(1'b1, 1'b0, '1, AW'(a), {NBANK{EW'(a * 3)}}, 1'b0, '0);
    for (int a = 0; a < 16; a++) begin
      step(1'b1, 1'b0, '0, '0, '0, 1'b1, AW'(a));
      chk("stream_data", dout, {NBANK{EW'(a * 3)}});
      chk("stream_vld", {{(DW-1){1'b0}}, dout_vld}, {{(DW-1){1'b0}}, 1'b1});
    end
    idle_step();
    chk("gap_dout", dout, '0);
    chk("gap_vld", {{(DW-1){1'b0}}, dout_vld}, '0);

    // clr_start from idle wipes written data; stray clr_start mid-clear ignored
    step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0);
    count_busy("clr_start_len");
    check_zero_range("clr_start_zero", 0, 15);

    // Reset at clear count 200 restarts the full clear
    for (int a = 0; a < 16; a++) step(1'b1, 1'b0, '1, AW'(a), rand_d(), 1'b0, '0);
    step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 200; i++) idle_step();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    count_busy("restart_clear_len");
    check_zero_range("restart_zero", 0, 31);

    // Random traffic against the model, with rare clears and resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 999) != 0), ($urandom_range(0, 399) == 0),
           NBANK'($urandom()) & NBANK'($urandom()),
           AW'(($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, 15)), rand_d(),
           1'($urandom()),
           AW'(($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
